// File: rtl/micro_step_sequencer_pkg.sv
// Shared definitions for the micro-step sequencer and the microcode control unit:
// state encoding and the default micro-step geometry.
package micro_step_sequencer_pkg;

    localparam int DEFAULT_LAST_STEP    = 4;
    localparam int DEFAULT_STEP_WIDTH   = 3;
    localparam int DEFAULT_ICOUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_LOAD   = 3'd4
    } state_t;

    // The datapath clock enable is a pure function of the sequencer state.
    function automatic logic is_cpu_enabled(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/micro_step_counter.sv
// Micro-step counter with advance/wrap/sync-clear, the one-cycle Instruction_Done
// pulse and the free-running retired-instruction counter.
module micro_step_counter
    import micro_step_sequencer_pkg::*;
#(
    parameter int LAST_STEP    = DEFAULT_LAST_STEP,
    parameter int STEP_WIDTH   = DEFAULT_STEP_WIDTH,
    parameter int ICOUNT_WIDTH = DEFAULT_ICOUNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_advance,
    input  logic                    i_early_end,
    input  logic                    i_clear,
    output logic                    o_wrap,
    output logic [STEP_WIDTH-1:0]   o_count,
    output logic                    o_done,
    output logic [ICOUNT_WIDTH-1:0] o_icount
);

    localparam logic [STEP_WIDTH-1:0] LAST_CODE = STEP_WIDTH'(LAST_STEP);

    logic [STEP_WIDTH-1:0]   r_count;
    logic                    r_done;
    logic [ICOUNT_WIDTH-1:0] r_icount;
    logic                    w_last;

    assign w_last   = (r_count == LAST_CODE) || i_early_end;
    assign o_wrap   = i_advance && w_last;
    assign o_count  = r_count;
    assign o_done   = r_done;
    assign o_icount = r_icount;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_done   <= 1'b0;
            r_icount <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_clear) begin
                r_count <= '0;
            end else if (i_advance) begin
                if (w_last) begin
                    r_count  <= '0;
                    r_done   <= 1'b1;
                    r_icount <= r_icount + 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/micro_step_sequencer.sv
// Run/step/halt/load sequencer for the microcode control unit. Owns the datapath
// clock enable and hands RAM/bus to the program loader only at instruction boundaries.
module micro_step_sequencer
    import micro_step_sequencer_pkg::*;
#(
    parameter int LAST_STEP    = DEFAULT_LAST_STEP,
    parameter int STEP_WIDTH   = DEFAULT_STEP_WIDTH,
    parameter int ICOUNT_WIDTH = DEFAULT_ICOUNT_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    Run_Mode,
    input  logic                    Step_Pulse,
    input  logic                    Restart,
    input  logic                    Halt_Signal,
    input  logic                    Early_End,
    input  logic                    Loader_Req,
    output logic [STEP_WIDTH-1:0]   Micro_Count,
    output logic                    Cpu_Enable,
    output logic                    Instruction_Done,
    output logic                    Halted,
    output logic                    Loader_Grant,
    output logic                    Pc_Clear,
    output logic [ICOUNT_WIDTH-1:0] Instruction_Count,
    output state_t                  Dbg_State
);

    state_t r_state;
    state_t w_next_state;
    logic   r_cpu_enable;
    logic   r_halted;
    logic   r_loader_grant;
    logic   r_pc_clear;
    logic   w_advance;
    logic   w_clear;
    logic   w_wrap;
    logic   w_count_zero;

    // A halt in the same cycle as a would-be wrap wins: the counter must not move.
    assign w_advance    = r_cpu_enable && !Halt_Signal;
    assign w_clear      = (r_state == ST_HALTED) && (Restart || Loader_Req);
    assign w_count_zero = (Micro_Count == '0);

    micro_step_counter #(
        .LAST_STEP    (LAST_STEP),
        .STEP_WIDTH   (STEP_WIDTH),
        .ICOUNT_WIDTH (ICOUNT_WIDTH)
    ) u_counter (
        .i_clk       (CLK),
        .i_rst_n     (RESET_N),
        .i_advance   (w_advance),
        .i_early_end (Early_End),
        .i_clear     (w_clear),
        .o_wrap      (w_wrap),
        .o_count     (Micro_Count),
        .o_done      (Instruction_Done),
        .o_icount    (Instruction_Count)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Loader_Req && w_count_zero) w_next_state = ST_LOAD;
                else if (Run_Mode)              w_next_state = ST_RUN;
                else if (Step_Pulse)            w_next_state = ST_STEP;
            end
            ST_RUN: begin
                if (Halt_Signal)                               w_next_state = ST_HALTED;
                else if (w_wrap && (Loader_Req || !Run_Mode))  w_next_state = ST_IDLE;
            end
            ST_STEP: begin
                if (Halt_Signal)  w_next_state = ST_HALTED;
                else if (w_wrap)  w_next_state = ST_IDLE;
            end
            ST_HALTED: begin
                if (Loader_Req)   w_next_state = ST_LOAD;
                else if (Restart) w_next_state = ST_IDLE;
            end
            ST_LOAD: begin
                if (!Loader_Req)  w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Status outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= ST_IDLE;
            r_cpu_enable   <= 1'b0;
            r_halted       <= 1'b0;
            r_loader_grant <= 1'b0;
            r_pc_clear     <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cpu_enable   <= is_cpu_enabled(w_next_state);
            r_halted       <= (w_next_state == ST_HALTED);
            r_loader_grant <= (w_next_state == ST_LOAD);
            r_pc_clear     <= ((r_state == ST_HALTED) && Restart && !Loader_Req)
                           || ((r_state == ST_LOAD) && !Loader_Req);
        end
    end

    assign Cpu_Enable   = r_cpu_enable;
    assign Halted       = r_halted;
    assign Loader_Grant = r_loader_grant;
    assign Pc_Clear     = r_pc_clear;
    assign Dbg_State    = r_state;

    ap_grant_cpu_exclusive: assert property (@(posedge CLK) disable iff (!RESET_N)
        !(Loader_Grant && Cpu_Enable));
    ap_pc_clear_single: assert property (@(posedge CLK) disable iff (!RESET_N)
        Pc_Clear |=> !Pc_Clear);
    ap_halted_frozen: assert property (@(posedge CLK) disable iff (!RESET_N)
        Halted |-> !Cpu_Enable);

endmodule

// File: tb/tb_micro_step_sequencer.sv
// Directed bench for micro_step_sequencer: run, step, halt, loader handshake,
// early end, asynchronous reset and instruction-counter wrap.
module tb_micro_step_sequencer;
    import micro_step_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        Run_Mode = 1'b0;
    logic        Step_Pulse = 1'b0;
    logic        Restart = 1'b0;
    logic        Halt_Signal = 1'b0;
    logic        Early_End = 1'b0;
    logic        Loader_Req = 1'b0;
    logic [2:0]  Micro_Count;
    logic        Cpu_Enable;
    logic        Instruction_Done;
    logic        Halted;
    logic        Loader_Grant;
    logic        Pc_Clear;
    logic [15:0] Instruction_Count;
    state_t      Dbg_State;

    int checks = 0;
    int errors = 0;
    int exp_icount = 0;

    micro_step_sequencer dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .Run_Mode          (Run_Mode),
        .Step_Pulse        (Step_Pulse),
        .Restart           (Restart),
        .Halt_Signal       (Halt_Signal),
        .Early_End         (Early_End),
        .Loader_Req        (Loader_Req),
        .Micro_Count       (Micro_Count),
        .Cpu_Enable        (Cpu_Enable),
        .Instruction_Done  (Instruction_Done),
        .Halted            (Halted),
        .Loader_Grant      (Loader_Grant),
        .Pc_Clear          (Pc_Clear),
        .Instruction_Count (Instruction_Count),
        .Dbg_State         (Dbg_State)
    );

    always #5 CLK = ~CLK;

    task automatic step_cycle();
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        checks++;
        if (Loader_Grant && Cpu_Enable) begin
            errors++;
            $display("FAIL grant_cpu_exclusive: grant=%0b cpu_enable=%0b, required not both 1", Loader_Grant, Cpu_Enable);
        end
    end

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) step_cycle();
        checks++;
        if (Micro_Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Micro_Count); end
        checks++;
        if (Instruction_Count !== 16'd0) begin errors++; $display("FAIL reset_icount: got %0h expected 0", Instruction_Count); end
        checks++;
        if ({Cpu_Enable, Instruction_Done, Halted, Loader_Grant, Pc_Clear} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {Cpu_Enable, Instruction_Done, Halted, Loader_Grant, Pc_Clear});
        end
        RESET_N = 1'b1;
        repeat (2) step_cycle();
        checks++;
        if (Dbg_State !== ST_IDLE || Cpu_Enable !== 1'b0) begin
            errors++; $display("FAIL reset_idle: state %0d cpu_en %0b expected state 0 cpu_en 0", Dbg_State, Cpu_Enable);
        end
    endtask

    task automatic test_run();
        int done_seen = 0;
        Run_Mode = 1'b1;
        checks++;
        if (Cpu_Enable !== 1'b0) begin errors++; $display("FAIL run_enable_delay: got %0b expected 0", Cpu_Enable); end
        for (int i = 0; i < 15; i++) begin
            step_cycle();
            checks++;
            if (Micro_Count !== 3'(i % 5)) begin errors++; $display("FAIL run_count[%0d]: got %0d expected %0d", i, Micro_Count, i % 5); end
            checks++;
            if (Cpu_Enable !== 1'b1) begin errors++; $display("FAIL run_cpu_en[%0d]: got %0b expected 1", i, Cpu_Enable); end
            checks++;
            if (Instruction_Done !== ((i % 5 == 0) && (i > 0))) begin
                errors++; $display("FAIL run_done[%0d]: got %0b expected %0b", i, Instruction_Done, (i % 5 == 0) && (i > 0));
            end
            if (Instruction_Done === 1'b1) done_seen++;
            if (i == 14) Run_Mode = 1'b0;
        end
        step_cycle();
        exp_icount += 3;
        if (Instruction_Done === 1'b1) done_seen++;
        checks++;
        if (done_seen != 3) begin errors++; $display("FAIL run_done_total: got %0d expected 3", done_seen); end
        checks++;
        if (Instruction_Count !== 16'(exp_icount)) begin errors++; $display("FAIL run_icount: got %0d expected %0d", Instruction_Count, exp_icount); end
        checks++;
        if (Dbg_State !== ST_IDLE || Micro_Count !== 3'd0 || Cpu_Enable !== 1'b0) begin
            errors++; $display("FAIL run_stop: state %0d count %0d cpu_en %0b expected 0 0 0", Dbg_State, Micro_Count, Cpu_Enable);
        end
    endtask

    task automatic test_step();
        int enabled = 0;
        Step_Pulse = 1'b1;
        step_cycle();
        Step_Pulse = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Micro_Count !== 3'(i)) begin errors++; $display("FAIL step_count[%0d]: got %0d expected %0d", i, Micro_Count, i); end
            if (Cpu_Enable === 1'b1) enabled++;
            Step_Pulse = (i == 2);
            step_cycle();
        end
        Step_Pulse = 1'b0;
        exp_icount++;
        checks++;
        if (enabled != 5) begin errors++; $display("FAIL step_enabled_cycles: got %0d expected 5", enabled); end
        checks++;
        if (Dbg_State !== ST_IDLE || Micro_Count !== 3'd0 || Cpu_Enable !== 1'b0 || Instruction_Done !== 1'b1) begin
            errors++; $display("FAIL step_end: state %0d count %0d cpu_en %0b done %0b expected 0 0 0 1", Dbg_State, Micro_Count, Cpu_Enable, Instruction_Done);
        end
        checks++;
        if (Instruction_Count !== 16'(exp_icount)) begin errors++; $display("FAIL step_icount: got %0d expected %0d", Instruction_Count, exp_icount); end
        step_cycle();
        checks++;
        if (Dbg_State !== ST_IDLE || Cpu_Enable !== 1'b0 || Instruction_Done !== 1'b0) begin
            errors++; $display("FAIL step_second_pulse_ignored: state %0d cpu_en %0b done %0b expected 0 0 0", Dbg_State, Cpu_Enable, Instruction_Done);
        end
    endtask

    task automatic test_halt();
        Run_Mode = 1'b1;
        step_cycle();
        repeat (3) step_cycle();
        checks++;
        if (Micro_Count !== 3'd3) begin errors++; $display("FAIL halt_pre_count: got %0d expected 3", Micro_Count); end
        Halt_Signal = 1'b1;
        step_cycle();
        Halt_Signal = 1'b0;
        Run_Mode = 1'b0;
        checks++;
        if (Halted !== 1'b1 || Cpu_Enable !== 1'b0 || Dbg_State !== ST_HALTED) begin
            errors++; $display("FAIL halt_enter: halted %0b cpu_en %0b state %0d expected 1 0 3", Halted, Cpu_Enable, Dbg_State);
        end
        checks++;
        if (Micro_Count !== 3'd3 || Instruction_Done !== 1'b0) begin
            errors++; $display("FAIL halt_frozen: count %0d done %0b expected 3 0", Micro_Count, Instruction_Done);
        end
        step_cycle();
        checks++;
        if (Micro_Count !== 3'd3 || Halted !== 1'b1 || Instruction_Count !== 16'(exp_icount)) begin
            errors++; $display("FAIL halt_hold: count %0d halted %0b icount %0d expected 3 1 %0d", Micro_Count, Halted, Instruction_Count, exp_icount);
        end
        Restart = 1'b1;
        step_cycle();
        Restart = 1'b0;
        checks++;
        if (Pc_Clear !== 1'b1 || Micro_Count !== 3'd0 || Dbg_State !== ST_IDLE || Halted !== 1'b0) begin
            errors++; $display("FAIL halt_restart: pc_clear %0b count %0d state %0d halted %0b expected 1 0 0 0", Pc_Clear, Micro_Count, Dbg_State, Halted);
        end
        step_cycle();
        checks++;
        if (Pc_Clear !== 1'b0 || Dbg_State !== ST_IDLE) begin
            errors++; $display("FAIL halt_pc_clear_pulse: pc_clear %0b state %0d expected 0 0", Pc_Clear, Dbg_State);
        end
    endtask

    task automatic test_halt_on_wrap();
        Run_Mode = 1'b1;
        step_cycle();
        repeat (4) step_cycle();
        checks++;
        if (Micro_Count !== 3'd4) begin errors++; $display("FAIL hwrap_pre_count: got %0d expected 4", Micro_Count); end
        Halt_Signal = 1'b1;
        step_cycle();
        Halt_Signal = 1'b0;
        Run_Mode = 1'b0;
        checks++;
        if (Dbg_State !== ST_HALTED || Micro_Count !== 3'd4 || Instruction_Done !== 1'b0 || Instruction_Count !== 16'(exp_icount)) begin
            errors++; $display("FAIL hwrap_no_retire: state %0d count %0d done %0b icount %0d expected 3 4 0 %0d", Dbg_State, Micro_Count, Instruction_Done, Instruction_Count, exp_icount);
        end
        Loader_Req = 1'b1;
        Restart = 1'b1;
        step_cycle();
        Restart = 1'b0;
        checks++;
        if (Dbg_State !== ST_LOAD || Loader_Grant !== 1'b1 || Micro_Count !== 3'd0 || Pc_Clear !== 1'b0 || Halted !== 1'b0) begin
            errors++; $display("FAIL hwrap_load_priority: state %0d grant %0b count %0d pc_clear %0b halted %0b expected 4 1 0 0 0", Dbg_State, Loader_Grant, Micro_Count, Pc_Clear, Halted);
        end
        Loader_Req = 1'b0;
        step_cycle();
        checks++;
        if (Loader_Grant !== 1'b0 || Pc_Clear !== 1'b1 || Dbg_State !== ST_IDLE) begin
            errors++; $display("FAIL hwrap_load_exit: grant %0b pc_clear %0b state %0d expected 0 1 0", Loader_Grant, Pc_Clear, Dbg_State);
        end
        step_cycle();
        checks++;
        if (Pc_Clear !== 1'b0) begin errors++; $display("FAIL hwrap_pc_clear_pulse: got %0b expected 0", Pc_Clear); end
    endtask

    task automatic test_loader();
        Run_Mode = 1'b1;
        step_cycle();
        step_cycle();
        checks++;
        if (Micro_Count !== 3'd1) begin errors++; $display("FAIL load_pre_count: got %0d expected 1", Micro_Count); end
        Loader_Req = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            step_cycle();
            checks++;
            if (Micro_Count !== 3'(i) || Cpu_Enable !== 1'b1 || Loader_Grant !== 1'b0) begin
                errors++; $display("FAIL load_finish[%0d]: count %0d cpu_en %0b grant %0b expected %0d 1 0", i, Micro_Count, Cpu_Enable, Loader_Grant, i);
            end
        end
        step_cycle();
        exp_icount++;
        Run_Mode = 1'b0;
        checks++;
        if (Dbg_State !== ST_IDLE || Micro_Count !== 3'd0 || Instruction_Done !== 1'b1 || Loader_Grant !== 1'b0 || Cpu_Enable !== 1'b0) begin
            errors++; $display("FAIL load_boundary: state %0d count %0d done %0b grant %0b cpu_en %0b expected 0 0 1 0 0", Dbg_State, Micro_Count, Instruction_Done, Loader_Grant, Cpu_Enable);
        end
        step_cycle();
        checks++;
        if (Dbg_State !== ST_LOAD || Loader_Grant !== 1'b1 || Cpu_Enable !== 1'b0) begin
            errors++; $display("FAIL load_grant: state %0d grant %0b cpu_en %0b expected 4 1 0", Dbg_State, Loader_Grant, Cpu_Enable);
        end
        repeat (2) step_cycle();
        checks++;
        if (Loader_Grant !== 1'b1) begin errors++; $display("FAIL load_hold: grant %0b expected 1", Loader_Grant); end
        Loader_Req = 1'b0;
        step_cycle();
        checks++;
        if (Loader_Grant !== 1'b0 || Pc_Clear !== 1'b1 || Dbg_State !== ST_IDLE) begin
            errors++; $display("FAIL load_release: grant %0b pc_clear %0b state %0d expected 0 1 0", Loader_Grant, Pc_Clear, Dbg_State);
        end
        step_cycle();
        checks++;
        if (Pc_Clear !== 1'b0) begin errors++; $display("FAIL load_pc_clear_pulse: got %0b expected 0", Pc_Clear); end
    endtask

    task automatic test_early_end();
        Run_Mode = 1'b1;
        repeat (3) step_cycle();
        checks++;
        if (Micro_Count !== 3'd2) begin errors++; $display("FAIL early_pre_count: got %0d expected 2", Micro_Count); end
        Early_End = 1'b1;
        step_cycle();
        Early_End = 1'b0;
        exp_icount++;
        checks++;
        if (Micro_Count !== 3'd0 || Instruction_Done !== 1'b1 || Dbg_State !== ST_RUN) begin
            errors++; $display("FAIL early_wrap: count %0d done %0b state %0d expected 0 1 1", Micro_Count, Instruction_Done, Dbg_State);
        end
        checks++;
        if (Instruction_Count !== 16'(exp_icount)) begin errors++; $display("FAIL early_icount: got %0d expected %0d", Instruction_Count, exp_icount); end
        Run_Mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (Micro_Count !== 3'(i) || Cpu_Enable !== 1'b1) begin
                errors++; $display("FAIL early_drain[%0d]: count %0d cpu_en %0b expected %0d 1", i, Micro_Count, Cpu_Enable, i);
            end
            step_cycle();
        end
        exp_icount++;
        checks++;
        if (Dbg_State !== ST_IDLE || Instruction_Count !== 16'(exp_icount)) begin
            errors++; $display("FAIL early_stop: state %0d icount %0d expected 0 %0d", Dbg_State, Instruction_Count, exp_icount);
        end
    endtask

    task automatic test_async_reset();
        Run_Mode = 1'b1;
        step_cycle();
        repeat (3) step_cycle();
        checks++;
        if (Micro_Count !== 3'd3 || Cpu_Enable !== 1'b1) begin
            errors++; $display("FAIL areset_pre: count %0d cpu_en %0b expected 3 1", Micro_Count, Cpu_Enable);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (Micro_Count !== 3'd0 || Instruction_Count !== 16'd0 || {Cpu_Enable, Instruction_Done, Halted, Loader_Grant, Pc_Clear} !== 5'b0) begin
            errors++; $display("FAIL areset_immediate: count %0d icount %0d flags %b expected 0 0 00000", Micro_Count, Instruction_Count, {Cpu_Enable, Instruction_Done, Halted, Loader_Grant, Pc_Clear});
        end
        Run_Mode = 1'b0;
        exp_icount = 0;
        repeat (2) step_cycle();
        RESET_N = 1'b1;
        repeat (3) step_cycle();
        checks++;
        if (Dbg_State !== ST_IDLE || Cpu_Enable !== 1'b0 || Micro_Count !== 3'd0) begin
            errors++; $display("FAIL areset_idle: state %0d cpu_en %0b count %0d expected 0 0 0", Dbg_State, Cpu_Enable, Micro_Count);
        end
    endtask

    task automatic test_icount_wrap();
        Run_Mode = 1'b1;
        Early_End = 1'b1;
        step_cycle();
        repeat (65535) step_cycle();
        checks++;
        if (Instruction_Count !== 16'hFFFF) begin errors++; $display("FAIL icount_max: got %0h expected ffff", Instruction_Count); end
        step_cycle();
        checks++;
        if (Instruction_Count !== 16'h0000 || Micro_Count !== 3'd0) begin
            errors++; $display("FAIL icount_wrap: icount %0h count %0d expected 0 0", Instruction_Count, Micro_Count);
        end
        Run_Mode = 1'b0;
        step_cycle();
        Early_End = 1'b0;
        checks++;
        if (Dbg_State !== ST_IDLE || Instruction_Count !== 16'h0001) begin
            errors++; $display("FAIL icount_after_wrap: state %0d icount %0h expected 0 1", Dbg_State, Instruction_Count);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_halt();
        test_halt_on_wrap();
        test_loader();
        test_early_end();
        test_async_reset();
        test_icount_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
